// File: rtl/param_ram.sv
// Single-port synchronous RAM. After reset or a clr request, a built-in sweep writes zero to every word.
// Reads return after READ_LAT (1 or 2) edges with a one-cycle valid strobe; accesses raise err while busy.
module param_ram #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 6,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CS,
   input  logic              wr,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] Di,
   input  logic              clr,
   output logic [DATA_W-1:0] Do,
   output logic              Do_valid,
   output logic              busy,
   output logic              err
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              busy_w, acc_ok, rd_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdat;

   logic [DATA_W-1:0] rd1_dat_q;
   logic              rd1_vld_q;
   logic [DATA_W-1:0] out_dat;
   logic              out_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // The counter wraps to zero on the final sweep write, so READY always holds it at 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = ST_READY;
         end
         ST_READY: begin
            if (clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_comb begin
      busy_w   = (state_q == ST_CLEAR);
      acc_ok   = (state_q == ST_READY) && CS && !clr;
      rd_en    = acc_ok && !wr;
      mem_we   = busy_w || (acc_ok && wr);
      mem_addr = busy_w ? cnt_q : address;
      mem_wdat = busy_w ? '0 : Di;
      err_d    = busy_w && CS;
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd1_vld_q <= 1'b0;
         rd1_dat_q <= '0;
      end else begin
         rd1_vld_q <= rd_en;
         rd1_dat_q <= rd_en ? mem[address] : '0;
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic [DATA_W-1:0] rd2_dat_q;
         logic              rd2_vld_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd2_vld_q <= 1'b0;
               rd2_dat_q <= '0;
            end else begin
               rd2_vld_q <= rd1_vld_q;
               rd2_dat_q <= rd1_dat_q;
            end
         end
         assign out_dat = rd2_dat_q;
         assign out_vld = rd2_vld_q;
      end else begin : g_lat1
         assign out_dat = rd1_dat_q;
         assign out_vld = rd1_vld_q;
      end
   endgenerate

   // Registered pipeline data is already zero when idle; the gate also keeps Do clean asynchronously.
   assign Do       = out_vld ? out_dat : '0;
   assign Do_valid = out_vld;
   assign busy     = busy_w;
   assign err      = err_q;
endmodule

// File: tb/tb_param_ram.sv
// Bench for param_ram: READ_LAT=1 and READ_LAT=2 instances share stimulus and are checked
// against an array/queue reference model of memory, sweep and read returns.
module tb_param_ram;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cs = 1'b0, wr = 1'b0, clr = 1'b0;
   logic [5:0] addr = '0;
   logic [7:0] di = '0;

   logic [7:0] dout1, dout2;
   logic       vld1, vld2, busy1, busy2, err1, err2;

   param_ram #(.DATA_W(8), .ADDR_W(6), .READ_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .CS(cs), .wr(wr), .address(addr), .Di(di), .clr(clr),
      .Do(dout1), .Do_valid(vld1), .busy(busy1), .err(err1)
   );
   param_ram #(.DATA_W(8), .ADDR_W(6), .READ_LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .CS(cs), .wr(wr), .address(addr), .Di(di), .clr(clr),
      .Do(dout2), .Do_valid(vld2), .busy(busy2), .err(err2)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: memory contents, sweep progress, and a log of issued reads stamped by edge.
   typedef struct {
      int         e;
      logic [7:0] d;
   } rd_t;

   logic [7:0] m_mem [64];
   bit         m_busy;
   bit         m_err;
   int         m_cnt;
   int         edge_n = 0;
   rd_t        rq[$];

   task automatic model_reset();
      m_busy = 1'b1;
      m_err  = 1'b0;
      m_cnt  = 0;
      rq.delete();
   endtask

   task automatic model_edge();
      rd_t r;
      m_err = m_busy && cs;
      if (m_busy) begin
         m_mem[m_cnt] = 8'h00;
         m_cnt++;
         if (m_cnt == 64) begin
            m_busy = 1'b0;
            m_cnt  = 0;
         end
      end else if (clr) begin
         m_busy = 1'b1;
         m_cnt  = 0;
      end else if (cs && wr) begin
         m_mem[addr] = di;
      end else if (cs) begin
         r.e = edge_n;
         r.d = m_mem[addr];
         rq.push_back(r);
      end
      while (rq.size() > 0 && rq[0].e < edge_n - 2) void'(rq.pop_front());
   endtask

   task automatic check_outputs();
      logic [7:0] e1, e2;
      logic       v1, v2;
      e1 = '0; e2 = '0; v1 = 1'b0; v2 = 1'b0;
      foreach (rq[i]) begin
         if (rq[i].e == edge_n) begin v1 = 1'b1; e1 = rq[i].d; end
         if (rq[i].e == edge_n - 1) begin v2 = 1'b1; e2 = rq[i].d; end
      end
      chk("busy_l1", busy1, m_busy);
      chk("busy_l2", busy2, m_busy);
      chk("err_l1", err1, m_err);
      chk("err_l2", err2, m_err);
      chk("do_l1", dout1, e1);
      chk("vld_l1", vld1, v1);
      chk("do_l2", dout2, e2);
      chk("vld_l2", vld2, v2);
   endtask

   task automatic tick();
      @(posedge clk);
      edge_n++;
      if (rst) model_reset();
      else model_edge();
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic c, input logic w, input logic [5:0] a, input logic [7:0] d, input logic cl);
      cs = c; wr = w; addr = a; di = d; clr = cl;
   endtask

   task automatic do_wr(input logic [5:0] a, input logic [7:0] d);
      drive(1'b1, 1'b1, a, d, 1'b0);
      tick();
   endtask

   task automatic do_rd(input logic [5:0] a);
      drive(1'b1, 1'b0, a, 8'h00, 1'b0);
      tick();
   endtask

   task automatic idle(input int n);
      drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b0);
      repeat (n) tick();
   endtask

   // Counts edges until busy falls; inject_at >= 0 places one write attempt inside the sweep.
   task automatic sweep_len(input string tag, input int inject_at);
      int n;
      n = 0;
      while (busy1 && n < 200) begin
         if (n == inject_at) drive(1'b1, 1'b1, 6'd7, 8'hFF, 1'b0);
         else drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b0);
         tick();
         n++;
      end
      chk(tag, n, 64);
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk({tag, "_do1"}, dout1, 0);
      chk({tag, "_vld1"}, vld1, 0);
      chk({tag, "_do2"}, dout2, 0);
      chk({tag, "_vld2"}, vld2, 0);
      chk({tag, "_busy"}, busy1, 1);
      idle(2);
      rst = 1'b0;
   endtask

   initial begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      model_reset();
      #1 rst = 1'b1;
      #1;
      check_outputs();
      idle(3);
      rst = 1'b0;

      // First sweep with one write attempt while busy
      sweep_len("sweep_rst", 10);
      idle(1);
      do_rd(6'd0); do_rd(6'd31); do_rd(6'd63); do_rd(6'd7);
      idle(3);

      // Write/readback, back-to-back reads
      do_wr(6'd5, 8'hA5);
      do_wr(6'd63, 8'h3C);
      do_rd(6'd5);
      do_rd(6'd63);
      idle(3);
      chk("rb_after_do2", dout2, 0);

      // Write then read same address on the next edge
      do_wr(6'd20, 8'h5E);
      do_rd(6'd20);
      idle(2);

      // clr together with a write: write dropped, no err, full sweep
      do_wr(6'd9, 8'h11);
      drive(1'b1, 1'b1, 6'd10, 8'h22, 1'b1);
      tick();
      chk("clr_no_err", err1, 0);
      sweep_len("sweep_clr", -1);
      do_rd(6'd9); do_rd(6'd10);
      idle(3);

      // Randomized traffic
      for (int k = 0; k < 1500; k++) begin
         drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
               $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63)),
               8'($urandom), $urandom_range(0, 299) == 0);
         tick();
      end
      idle(2);
      if (busy1) sweep_len("sweep_rand", -1);

      // Reset with the sweep counter at 30
      drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
      tick();
      drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b0);
      for (int k = 0; k < 100 && m_cnt != 30; k++) tick();
      chk("cnt_at_30", m_cnt, 30);
      async_reset("rst_sweep");
      sweep_len("sweep_after_rst", -1);

      // Reset with reads in flight
      do_wr(6'd3, 8'h77);
      do_rd(6'd3);
      chk("inflight_vld1", vld1, 1);
      async_reset("rst_read");
      sweep_len("sweep_after_rst2", -1);
      do_rd(6'd3);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
